// File: rtl/vertex_transform_sequencer.sv
// Purpose : sequences vertices from a vertex buffer through a 4x4 matrix-vector
//           multiplier and writes each transformed vertex to a clip-space buffer.
// Latency : 10 cycles per vertex with no stalls; done pulses 10n+1 cycles after start.
// Backpr. : mul_o_ready low holds ISSUE; out_ready low holds WRITE. Each low cycle adds one cycle.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   start, num_vertices, mvp  run request; count and matrix are sampled on start in IDLE
//   vtx_rd_en, vtx_addr       vertex buffer read port (vtx_data returns one cycle later)
//   mul_A, mul_x, mul_i_dv    request side of the multiplier (valid/ready with mul_o_ready)
//   mul_o_dv, mul_y           response side of the multiplier (mul_y valid the cycle after mul_o_dv)
//   out_we/addr/data          clip-space write port, accepted on out_we && out_ready
//   busy, done                status: busy outside IDLE, done one-cycle end-of-run pulse
module vertex_transform_sequencer #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic [ADDRWIDTH:0]                  num_vertices,
  input  logic [3:0][3:0][DATAWIDTH-1:0]      mvp,
  output logic                                vtx_rd_en,
  output logic [ADDRWIDTH-1:0]                vtx_addr,
  input  logic [3:0][DATAWIDTH-1:0]           vtx_data,
  output logic [3:0][3:0][DATAWIDTH-1:0]      mul_A,
  output logic [3:0][DATAWIDTH-1:0]           mul_x,
  output logic                                mul_i_dv,
  input  logic                                mul_o_ready,
  input  logic                                mul_o_dv,
  input  logic [3:0][DATAWIDTH-1:0]           mul_y,
  output logic                                out_we,
  output logic [ADDRWIDTH-1:0]                out_addr,
  output logic [3:0][DATAWIDTH-1:0]           out_data,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_RES,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                           state_q;
  logic [3:0][3:0][DATAWIDTH-1:0]   mat_q;
  logic [3:0][DATAWIDTH-1:0]        vec_q;
  logic [ADDRWIDTH:0]               cnt_q;
  logic [ADDRWIDTH:0]               idx_q;
  logic                             vtx_rd_en_q;
  logic [ADDRWIDTH-1:0]             vtx_addr_q;
  logic                             mul_i_dv_q;
  logic                             out_we_q;
  logic [ADDRWIDTH-1:0]             out_addr_q;
  logic [3:0][DATAWIDTH-1:0]        out_data_q;
  logic                             busy_q;
  logic                             done_q;

  // The index carries one extra bit so a full 2^ADDRWIDTH run compares
  // against count-1 without wrapping the address first.
  logic [ADDRWIDTH:0]               idx_d;
  logic [ADDRWIDTH:0]               last_idx;
  logic                             is_last;

  assign idx_d    = idx_q + 1'b1;
  assign last_idx = cnt_q - 1'b1;
  assign is_last  = (idx_q == last_idx);

  // All outputs are registered; each state's output values are set on the
  // transition into that state so they are valid for the whole state cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      mat_q       <= '0;
      vec_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      vtx_rd_en_q <= 1'b0;
      vtx_addr_q  <= '0;
      mul_i_dv_q  <= 1'b0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mat_q  <= mvp;
            cnt_q  <= num_vertices;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (num_vertices == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_FETCH;
              vtx_rd_en_q <= 1'b1;
              vtx_addr_q  <= '0;
            end
          end
        end

        S_FETCH: begin
          vtx_rd_en_q <= 1'b0;
          state_q     <= S_WAIT_RD;
        end

        S_WAIT_RD: begin
          vec_q      <= vtx_data;
          mul_i_dv_q <= 1'b1;
          state_q    <= S_ISSUE;
        end

        // Operands come straight from mat_q/vec_q, which do not change here,
        // so holding the state is enough to keep the request stable.
        S_ISSUE: begin
          if (mul_o_ready) begin
            mul_i_dv_q <= 1'b0;
            state_q    <= S_WAIT_RES;
          end
        end

        S_WAIT_RES: begin
          if (mul_o_dv) begin
            state_q <= S_CAPTURE;
          end
        end

        // mul_y is valid the cycle after mul_o_dv, i.e. in this state.
        S_CAPTURE: begin
          out_data_q <= mul_y;
          out_addr_q <= idx_q[ADDRWIDTH-1:0];
          out_we_q   <= 1'b1;
          state_q    <= S_WRITE;
        end

        S_WRITE: begin
          if (out_ready) begin
            out_we_q <= 1'b0;
            if (is_last) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q       <= idx_d;
              vtx_rd_en_q <= 1'b1;
              vtx_addr_q  <= idx_d[ADDRWIDTH-1:0];
              state_q     <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign vtx_rd_en = vtx_rd_en_q;
  assign vtx_addr  = vtx_addr_q;
  assign mul_A     = mat_q;
  assign mul_x     = vec_q;
  assign mul_i_dv  = mul_i_dv_q;
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vertex_transform_sequencer.sv
module tb_vertex_transform_sequencer;

  localparam int DW = 32;
  localparam int AW = 2;

  typedef logic [3:0][DW-1:0]      v4_t;
  typedef logic [3:0][3:0][DW-1:0] mat_t;
  typedef struct {
    int   n;
    mat_t m;
    v4_t  v [4];
    v4_t  y [4];
    int   done_cyc;
  } row_t;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW:0]   num_vertices;
  mat_t          mvp;
  logic          vtx_rd_en;
  logic [AW-1:0] vtx_addr;
  v4_t           vtx_data;
  mat_t          mul_A;
  v4_t           mul_x;
  logic          mul_i_dv;
  logic          mul_o_ready;
  logic          mul_o_dv;
  v4_t           mul_y;
  logic          out_we;
  logic [AW-1:0] out_addr;
  v4_t           out_data;
  logic          out_ready;
  logic          busy;
  logic          done;

  vertex_transform_sequencer #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .num_vertices(num_vertices), .mvp(mvp),
    .vtx_rd_en(vtx_rd_en), .vtx_addr(vtx_addr), .vtx_data(vtx_data),
    .mul_A(mul_A), .mul_x(mul_x), .mul_i_dv(mul_i_dv), .mul_o_ready(mul_o_ready),
    .mul_o_dv(mul_o_dv), .mul_y(mul_y),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic v4_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] c, input logic [DW-1:0] d);
    v4_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic mat_t mkm(input v4_t r0, input v4_t r1, input v4_t r2, input v4_t r3);
    mat_t m;
    m[0] = r0; m[1] = r1; m[2] = r2; m[3] = r3;
    return m;
  endfunction

  function automatic v4_t matvec(input mat_t m, input v4_t x);
    v4_t y;
    for (int r = 0; r < 4; r++) begin
      y[r] = '0;
      for (int c = 0; c < 4; c++) y[r] = y[r] + m[r][c] * x[c];
    end
    return y;
  endfunction

  // Vertex buffer: one-cycle read latency.
  v4_t vmem [4];
  always @(posedge clk) begin
    if (vtx_rd_en) vtx_data <= vmem[vtx_addr];
  end

  // Multiplier: result pulse five cycles after the handshake, data one cycle later.
  mat_t mdl_a;
  v4_t  mdl_x;
  int   mul_t;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_t <= 0;
      mul_y <= '0;
    end else if (mul_i_dv && mul_o_ready) begin
      mul_t <= 1;
      mdl_a <= mul_A;
      mdl_x <= mul_x;
    end else if (mul_t == 5) begin
      mul_t <= 0;
      mul_y <= matvec(mdl_a, mdl_x);
    end else if (mul_t != 0) begin
      mul_t <= mul_t + 1;
    end
  end
  assign mul_o_dv = (mul_t == 5);

  // Activity monitors.
  logic [AW-1:0] wr_addr [$];
  v4_t           wr_data [$];
  int rd_cnt, hs_cnt, done_cnt, viol;
  initial viol = 0;
  always @(posedge clk) begin
    if (rstn) begin
      if (out_we && out_ready) begin
        wr_addr.push_back(out_addr);
        wr_data.push_back(out_data);
      end
      if (vtx_rd_en) rd_cnt++;
      if (mul_i_dv && mul_o_ready) hs_cnt++;
      if (done) done_cnt++;
      if (mul_i_dv && mul_t != 0) viol++;
    end
  end

  task automatic clr();
    wr_addr.delete();
    wr_data.delete();
    rd_cnt = 0; hs_cnt = 0; done_cnt = 0;
  endtask

  mat_t ident;

  // One run: start at cycle 0, out_ready low in cycles [ora,orb), mul_o_ready
  // low in [mra,mrb), optional start re-pulse at cycle rst_at.
  task automatic do_run(input string nm, input int n, input mat_t m, input v4_t v [4],
                        input v4_t y [4], input int exp_done, input int ora, input int orb,
                        input int mra, input int mrb, input int restart_at);
    int   cyc;
    bit   got;
    bit   stable;
    bit   issue_ok;
    bit   prev_we;
    int   we_cyc;
    logic [AW-1:0] pa;
    v4_t  pd;
    for (int i = 0; i < 4; i++) vmem[i] = v[i];
    clr();
    @(negedge clk);
    mvp = m; num_vertices = (AW+1)'(n); start = 1'b1;
    cyc = 0; got = 0; stable = 1; issue_ok = 1; prev_we = 0; we_cyc = 0;
    pa = '0; pd = '0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1; mvp = ident; num_vertices = (AW+1)'(3);
      end
      out_ready   = !(cyc >= ora && cyc < orb);
      mul_o_ready = !(cyc >= mra && cyc < mrb);
      if (cyc == 1) begin
        chk({nm, "_busy_c1"}, 512'(busy), 512'(1));
        chk({nm, "_rden_c1"}, 512'(vtx_rd_en), 512'(n != 0));
      end
      if (out_we) begin
        we_cyc++;
        if (prev_we && (out_addr !== pa || out_data !== pd)) stable = 0;
        pa = out_addr; pd = out_data;
      end
      prev_we = out_we;
      if (mul_i_dv && hs_cnt < 4 && (mul_A !== m || mul_x !== v[hs_cnt])) issue_ok = 0;
      if (done) got = 1;
    end
    chk({nm, "_done_seen"}, 512'(got), 512'(1));
    chk({nm, "_done_cyc"}, 512'(cyc), 512'(exp_done));
    chk({nm, "_nwr"}, 512'(wr_addr.size()), 512'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 512'(wr_addr[i]), 512'(i));
      chk($sformatf("%s_data%0d", nm, i), 512'(wr_data[i]), 512'(y[i]));
    end
    chk({nm, "_nrd"}, 512'(rd_cnt), 512'(n));
    chk({nm, "_nhs"}, 512'(hs_cnt), 512'(n));
    chk({nm, "_we_cycles"}, 512'(we_cyc), 512'(n + orb - ora));
    chk({nm, "_we_stable"}, 512'(stable), 512'(1));
    chk({nm, "_operands"}, 512'(issue_ok), 512'(1));
    @(negedge clk);
    chk({nm, "_busy_after"}, 512'(busy), 512'(0));
    chk({nm, "_done_1cyc"}, 512'(done), 512'(0));
    out_ready = 1'b1;
    mul_o_ready = 1'b1;
  endtask

  row_t tbl [5];
  v4_t  zv [4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int c;
    ident = mkm(mk(1,0,0,0), mk(0,1,0,0), mk(0,0,1,0), mk(0,0,0,1));
    for (int i = 0; i < 4; i++) zv[i] = '0;
    for (int t = 0; t < 5; t++) begin
      tbl[t].n = 0; tbl[t].m = '0; tbl[t].done_cyc = 0;
      for (int i = 0; i < 4; i++) begin tbl[t].v[i] = '0; tbl[t].y[i] = '0; end
    end
    // identity, single vertex
    tbl[0].n = 1; tbl[0].m = ident; tbl[0].done_cyc = 11;
    tbl[0].v[0] = mk(1,2,3,4); tbl[0].y[0] = mk(1,2,3,4);
    // diag(2,3,4,1), three vertices
    tbl[1].n = 3; tbl[1].done_cyc = 31;
    tbl[1].m = mkm(mk(2,0,0,0), mk(0,3,0,0), mk(0,0,4,0), mk(0,0,0,1));
    tbl[1].v[0] = mk(1,1,1,1); tbl[1].y[0] = mk(2,3,4,1);
    tbl[1].v[1] = mk(2,0,5,7); tbl[1].y[1] = mk(4,0,20,7);
    tbl[1].v[2] = mk(0,0,0,9); tbl[1].y[2] = mk(0,0,0,9);
    // empty run
    tbl[2].n = 0; tbl[2].m = ident; tbl[2].done_cyc = 1;
    // mixed matrix, two vertices
    tbl[3].n = 2; tbl[3].done_cyc = 21;
    tbl[3].m = mkm(mk(1,1,1,1), mk(0,1,0,0), mk(2,0,0,0), mk(0,0,0,1));
    tbl[3].v[0] = mk(5,6,7,8); tbl[3].y[0] = mk(26,6,10,8);
    tbl[3].v[1] = mk(1,0,0,0); tbl[3].y[1] = mk(1,0,2,0);
    // full-size run (2^ADDRWIDTH vertices), extreme data passes through unmodified
    tbl[4].n = 4; tbl[4].m = ident; tbl[4].done_cyc = 41;
    tbl[4].v[0] = mk(32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h7FFFFFFF);
    tbl[4].v[1] = mk(32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h1);
    tbl[4].v[2] = mk(0,0,0,0);
    tbl[4].v[3] = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 32'h0000FFFF);
    for (int i = 0; i < 4; i++) tbl[4].y[i] = tbl[4].v[i];

    rstn = 1'b0; start = 1'b0; num_vertices = '0; mvp = '0;
    out_ready = 1'b1; mul_o_ready = 1'b1;
    for (int i = 0; i < 4; i++) vmem[i] = '0;
    clr();
    repeat (2) @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_rden", 512'(vtx_rd_en), 512'(0));
    chk("rst_idv", 512'(mul_i_dv), 512'(0));
    chk("rst_we", 512'(out_we), 512'(0));
    chk("rst_mulA", 512'(mul_A), 512'(0));
    rstn = 1'b1;

    for (int t = 0; t < 5; t++)
      do_run($sformatf("vec%0d", t), tbl[t].n, tbl[t].m, tbl[t].v, tbl[t].y,
             tbl[t].done_cyc, 0, 0, 0, 0, -1);

    // out_ready low in WRITE cycles 10..12
    do_run("ostall", 1, tbl[0].m, tbl[0].v, tbl[0].y, 14, 10, 13, 0, 0, -1);
    // mul_o_ready low in ISSUE cycles 3..4
    do_run("mstall", 1, tbl[0].m, tbl[0].v, tbl[0].y, 13, 0, 0, 3, 5, -1);
    // start re-pulsed with identity mid-run must be ignored
    do_run("restart", 1, tbl[1].m, tbl[1].v, tbl[1].y, 11, 0, 0, 0, 0, 5);

    // reset during WAIT_RES
    for (int i = 0; i < 4; i++) vmem[i] = tbl[1].v[i];
    clr();
    @(negedge clk);
    mvp = tbl[1].m; num_vertices = (AW+1)'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c < 6) begin @(negedge clk); c++; end
    chk("ares_pre_busy", 512'(busy), 512'(1));
    rstn = 1'b0;
    #1;
    chk("ares_busy", 512'(busy), 512'(0));
    chk("ares_done", 512'(done), 512'(0));
    chk("ares_mulA", 512'(mul_A), 512'(0));
    chk("ares_mulx", 512'(mul_x), 512'(0));
    chk("ares_idv", 512'(mul_i_dv), 512'(0));
    chk("ares_out", 512'({out_we, out_addr, out_data}), 512'(0));
    chk("ares_rd", 512'({vtx_rd_en, vtx_addr}), 512'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("ares_no_done", 512'(done_cnt), 512'(0));
    chk("ares_no_write", 512'(wr_addr.size()), 512'(0));
    do_run("post_rst", 2, tbl[3].m, tbl[3].v, tbl[3].y, 21, 0, 0, 0, 0, -1);

    chk("single_outstanding", 512'(viol), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vertex_transform_sequencer.md
# vertex_transform_sequencer

Drives a 4x4 matrix-vector multiplier in the render pipeline: latches an MVP matrix, fetches homogeneous vertices from a vertex buffer, issues each vertex to the multiplier with the `i_dv`/`o_ready` handshake, and collects each result on `o_dv`. Transformed vertices are written to a clip-space buffer with a valid/ready write port. It sits between vertex memory and the multiplier, owning the request side and the response side of the multiplier protocol.

## Interface
- `DATAWIDTH`, 32, width of every matrix, vertex and result element.
- `ADDRWIDTH`, 8, vertex address width; up to 2^ADDRWIDTH vertices per run.

- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins a run when idle.
- `num_vertices`  in  ADDRWIDTH+1  vertex count, sampled on `start`.
- `mvp`  in  DATAWIDTH x[4][4]  matrix, sampled on `start`.
- `vtx_rd_en`  out  1  vertex buffer read strobe.
- `vtx_addr`  out  ADDRWIDTH  vertex read address.
- `vtx_data`  in  DATAWIDTH x[4]  read data, valid the cycle after `vtx_rd_en`.
- `mul_A`  out  DATAWIDTH x[4][4]  matrix to the multiplier.
- `mul_x`  out  DATAWIDTH x[4]  vector to the multiplier.
- `mul_i_dv`  out  1  request valid to the multiplier.
- `mul_o_ready`  in  1  multiplier can accept.
- `mul_o_dv`  in  1  multiplier result pulse.
- `mul_y`  in  DATAWIDTH x[4]  multiplier result, valid the cycle after `mul_o_dv`.
- `out_we`  out  1  write valid to the clip-space buffer.
- `out_addr`  out  ADDRWIDTH  write address; equals vertex index.
- `out_data`  out  DATAWIDTH x[4]  transformed vertex.
- `out_ready`  in  1  write accepted when `out_we && out_ready`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of run.

## Operation
- States: IDLE, FETCH, WAIT_RD, ISSUE, WAIT_RES, CAPTURE, WRITE, DONE.
- IDLE: on `start`, latch `mvp` into the matrix register and `num_vertices` into the count register, and clear the index. Go to DONE if the count is 0, otherwise go to FETCH. `start` in any other state is ignored.
- FETCH: `vtx_rd_en`=1, `vtx_addr`=index, then go to WAIT_RD.
- WAIT_RD: latch `vtx_data` into the vector register, then go to ISSUE.
- ISSUE: `mul_i_dv`=1. Handshake completes in the cycle where `mul_i_dv && mul_o_ready` holds; then go to WAIT_RES. If `mul_o_ready` is low, hold `mul_i_dv` and hold the operands stable.
- WAIT_RES: `mul_i_dv`=0. On `mul_o_dv`, go to CAPTURE.
- CAPTURE: latch `mul_y` into `out_data`, then go to WRITE.
- WRITE: `out_we`=1, hold `out_addr`/`out_data` until `out_ready`. On acceptance, if index == count-1 go to DONE; otherwise increment index and go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `mul_A` is driven continuously from the matrix register and `mul_x` from the vector register.
- No arithmetic on data; elements pass through unmodified. The index is ADDRWIDTH+1 bits internally, so count = 2^ADDRWIDTH terminates correctly with no address wrap before the last vertex.
- At most one multiplier transaction is outstanding. `mul_i_dv` is never asserted while awaiting `mul_o_dv`.

## Timing
- Reset (async, any state): state becomes IDLE. All outputs, including `mul_A`, `mul_x`, `out_data`, `out_addr` and `vtx_addr`, go to 0. `busy`, `done`, `out_we`, `vtx_rd_en` and `mul_i_dv` go to 0. Internal registers are cleared.
- Reset mid-run abandons the run. No `done` is pulsed. A `start` after reset release begins a fresh run.
- Per-vertex latency with `mul_o_ready` and `out_ready` held high is 10 cycles, broken down as: FETCH 1, WAIT_RD 1, ISSUE 1, WAIT_RES 5 (4 multiply cycles plus the `o_dv` cycle), CAPTURE 1, WRITE 1.
- `start` at cycle 0 puts the design in FETCH at cycle 1. For n vertices with no stalls, `done` asserts at cycle 10n+1. For n=0, `done` asserts at cycle 1.
- `busy` goes high the cycle after an accepted `start` and low the cycle after `done`.
- Each `out_ready`/`mul_o_ready` low cycle adds exactly one cycle of latency.

## Test plan
- Identity `mvp`, n=1, vertex [1,2,3,4] at addr 0 -> one write: `out_addr`=0, `out_data`=[1,2,3,4]; `done` at cycle 11.
- Diagonal `mvp` diag(2,3,4,1), n=3, vertices [1,1,1,1],[2,0,5,7],[0,0,0,9] -> writes at addr 0,1,2 of [2,3,4,1],[4,0,20,7],[0,0,0,9]; `done` at cycle 31.
- `num_vertices`=0 -> no `vtx_rd_en`, no `mul_i_dv`, no `out_we`; `done` at cycle 1; `busy` high for 1 cycle.
- n=1, `out_ready` low for 3 cycles in WRITE -> `out_we` held 4 cycles with stable addr/data; `done` at cycle 14.
- `start` re-pulsed with a different `mvp` mid-run -> ignored; results use the originally latched matrix.
- Reset asserted during WAIT_RES -> all outputs 0 immediately; no `done`; a new `start` after release gives correct results from addr 0.
